// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3/owner constants and response-stage record for the data-memory arbiter
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LD   = 1'b1;
  typedef struct packed {
    logic       valid;
    logic       owner;
    logic [2:0] funct3;
    logic [1:0] offset;
    logic       err;
  } resp_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane enables, store-data replication, misalign detection and load extraction/extension
module lsu_align
  import dmem_pkg::*;
(
  input  logic [2:0]  req_funct3_i,
  input  logic [1:0]  req_offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  input  logic [2:0]  rsp_funct3_i,
  input  logic [1:0]  rsp_offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] shifted;
  // request side: lanes follow the access size in funct3[1:0]; narrow data is replicated across lanes
  always_comb begin
    misaligned_o = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                   (req_funct3_i[1:0] == 2'b01 && req_offset_i[0]) ||
                   (req_funct3_i == F3_W && req_offset_i != 2'd0);
    be_o    = req_funct3_i[1:0] == 2'b00 ? 4'b0001 << req_offset_i :
              req_funct3_i[1:0] == 2'b01 ? (req_offset_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o = req_funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
              req_funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
  end
  // response side: shift the addressed lane down, then sign-extend unless funct3[2] marks unsigned
  always_comb begin
    shifted = rdata_i >> {rsp_offset_i, 3'b000};
    rdata_o = rsp_funct3_i[1:0] == 2'b00 ? {{24{!rsp_funct3_i[2] && shifted[7]}}, shifted[7:0]} :
              rsp_funct3_i[1:0] == 2'b01 ? {{16{!rsp_funct3_i[2] && shifted[15]}}, shifted[15:0]} :
              rdata_i;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/loader access to a 1-cycle-latency data memory with load alignment
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [XLEN-1:0]   core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [XLEN-1:0]   core_rdata,
  output logic              core_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [XLEN-1:0]   ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [XLEN-1:0]   ld_rdata,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [XLEN-1:0]   mem_w_data,
  input  logic [XLEN-1:0]   mem_r_data
);
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  resp_t             resp_q, resp_d;
  logic              core_mis;
  logic [3:0]        core_be;
  logic [XLEN-1:0]   core_wlane, core_rext;
  logic              unused_addr_hi;
  assign unused_addr_hi = ^core_addr[XLEN-1:ADDR_W+2];
  lsu_align u_align (
    .req_funct3_i (core_funct3),
    .req_offset_i (core_addr[1:0]),
    .wdata_i      (core_wdata),
    .be_o         (core_be),
    .wdata_o      (core_wlane),
    .misaligned_o (core_mis),
    .rsp_funct3_i (resp_q.funct3),
    .rsp_offset_i (resp_q.offset),
    .rdata_i      (mem_r_data),
    .rdata_o      (core_rext)
  );
  // grant favours whoever was not served last; the winner steers address, lanes and data
  always_comb begin
    core_gnt   = rst_n && core_req && (!ld_req || last_gnt_q == OWN_LD);
    ld_gnt     = rst_n && ld_req && (!core_req || last_gnt_q == OWN_CORE);
    last_gnt_d = core_gnt ? OWN_CORE : ld_gnt ? OWN_LD : last_gnt_q;
    addr_d     = core_gnt ? core_addr[ADDR_W+1:2] : ld_gnt ? ld_addr : addr_q;
    mem_r_addr = addr_d;
    mem_w_addr = addr_d;
    mem_we     = core_gnt ? (core_we && !core_mis ? core_be : 4'b0000) : ld_gnt && ld_we ? 4'b1111 : 4'b0000;
    mem_w_data = core_gnt ? core_wlane : ld_gnt ? ld_wdata : '0;
    resp_d.valid  = (core_gnt && (!core_we || core_mis)) || (ld_gnt && !ld_we);
    resp_d.owner  = ld_gnt ? OWN_LD : OWN_CORE;
    resp_d.funct3 = core_funct3;
    resp_d.offset = core_addr[1:0];
    resp_d.err    = core_gnt && core_mis;
  end
  // response outputs are gated to zero whenever their pulse is not active
  always_comb begin
    core_rvalid = resp_q.valid && resp_q.owner == OWN_CORE && !resp_q.err;
    core_err    = resp_q.valid && resp_q.owner == OWN_CORE && resp_q.err;
    ld_rvalid   = resp_q.valid && resp_q.owner == OWN_LD;
    core_rdata  = core_rvalid ? core_rext : '0;
    ld_rdata    = ld_rvalid ? mem_r_data : '0;
  end
  // arbiter history, held address and the single response stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= OWN_LD;
      addr_q     <= '0;
      resp_q     <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      resp_q     <= resp_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven grant/lane checks with a response scoreboard and reset corner cases
module tb_dmem_arbiter;
  import dmem_pkg::*;
  localparam int K_NONE = 0, K_CORE = 1, K_ERR = 2, K_LD = 3;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        core_req, core_we, core_gnt, core_rvalid, core_err;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [14:0] ld_addr, mem_r_addr, mem_w_addr;
  logic [31:0] ld_wdata, ld_rdata, mem_w_data, mem_r_data;
  logic [3:0]  mem_we;
  logic [31:0] mem [0:31];
  int checks = 0, failures = 0;

  typedef struct {
    logic cr; logic cw; logic [2:0] f3; logic [31:0] ca; logic [31:0] cd;
    logic lr; logic lw; logic [14:0] la; logic [31:0] ld;
    logic ecg; logic elg; logic [3:0] ewe; logic [14:0] eaddr; logic [31:0] ewd;
    int kind; logic [31:0] edata;
  } vec_t;
  typedef struct { int kind; logic [31:0] data; } rsp_t;
  vec_t v[23];
  rsp_t q[$];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_err(core_err), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .mem_we(mem_we),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[1] <= 32'h0000_0000;
      mem[2] <= 32'h8001_1234;
    end else
      for (int i = 0; i < 4; i++) if (mem_we[i]) mem[mem_w_addr[4:0]][8*i +: 8] <= mem_w_data[8*i +: 8];
    mem_r_data <= mem[mem_r_addr[4:0]];
  end

  function automatic vec_t mk(logic cr, logic cw, logic [2:0] f3, logic [31:0] ca, logic [31:0] cd,
                              logic lr, logic lw, logic [14:0] la, logic [31:0] ld,
                              logic ecg, logic elg, logic [3:0] ewe, logic [14:0] eaddr,
                              logic [31:0] ewd, int kind, logic [31:0] edata);
    vec_t t;
    t.cr = cr; t.cw = cw; t.f3 = f3; t.ca = ca; t.cd = cd;
    t.lr = lr; t.lw = lw; t.la = la; t.ld = ld;
    t.ecg = ecg; t.elg = elg; t.ewe = ewe; t.eaddr = eaddr; t.ewd = ewd;
    t.kind = kind; t.edata = edata;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    core_req = t.cr; core_we = t.cw; core_funct3 = t.f3; core_addr = t.ca; core_wdata = t.cd;
    ld_req = t.lr; ld_we = t.lw; ld_addr = t.la; ld_wdata = t.ld;
  endtask

  task automatic check_rsp();
    rsp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("core_rvalid", core_rvalid, e.kind == K_CORE);
      check("core_err", core_err, e.kind == K_ERR);
      check("ld_rvalid", ld_rvalid, e.kind == K_LD);
      check("core_rdata", core_rdata, e.kind == K_CORE ? e.data : 32'h0);
      check("ld_rdata", ld_rdata, e.kind == K_LD ? e.data : 32'h0);
    end
  endtask

  task automatic apply(input vec_t t);
    rsp_t e;
    @(negedge clk);
    check_rsp();
    drive(t);
    #1;
    check("core_gnt", core_gnt, t.ecg);
    check("ld_gnt", ld_gnt, t.elg);
    check("mem_we", mem_we, t.ewe);
    if (t.ecg || t.elg) begin
      check("mem_r_addr", mem_r_addr, t.eaddr);
      check("mem_w_addr", mem_w_addr, t.eaddr);
    end
    if (t.ewe != 4'b0000) check("mem_w_data", mem_w_data, t.ewd);
    e.kind = t.kind; e.data = t.edata;
    q.push_back(e);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,F3_B,0,0, 0,0,0,0, 0,0,4'b0000,0,0, K_NONE,0);
    v[0]  = mk(1,1,F3_B,32'h6,32'hA5, 1,0,15'd2,0, 1,0,4'b0100,15'd1,32'hA5A5_A5A5, K_NONE,0);
    v[1]  = mk(1,0,F3_B,32'h6,0, 0,0,0,0, 1,0,4'b0000,15'd1,0, K_CORE,32'hFFFF_FFA5);
    v[2]  = mk(1,0,F3_BU,32'h6,0, 0,0,0,0, 1,0,4'b0000,15'd1,0, K_CORE,32'h0000_00A5);
    v[3]  = mk(1,0,F3_H,32'hA,0, 0,0,0,0, 1,0,4'b0000,15'd2,0, K_CORE,32'hFFFF_8001);
    v[4]  = mk(1,0,F3_HU,32'hA,0, 0,0,0,0, 1,0,4'b0000,15'd2,0, K_CORE,32'h0000_8001);
    v[5]  = mk(1,0,F3_W,32'h2,0, 0,0,0,0, 1,0,4'b0000,15'd0,0, K_ERR,0);
    v[6]  = mk(1,1,F3_H,32'h3,32'h1234, 0,0,0,0, 1,0,4'b0000,15'd0,0, K_ERR,0);
    v[7]  = mk(1,1,F3_W,32'hC,32'hDEAD_BEEF, 0,0,0,0, 1,0,4'b1111,15'd3,32'hDEAD_BEEF, K_NONE,0);
    v[8]  = mk(0,0,F3_B,0,0, 1,0,15'd3,0, 0,1,4'b0000,15'd3,0, K_LD,32'hDEAD_BEEF);
    v[9]  = mk(0,0,F3_B,0,0, 1,1,15'd4,32'h1234_5678, 0,1,4'b1111,15'd4,32'h1234_5678, K_NONE,0);
    v[10] = mk(1,0,F3_W,32'h10,0, 0,0,0,0, 1,0,4'b0000,15'd4,0, K_CORE,32'h1234_5678);
    v[11] = mk(1,1,F3_H,32'h12,32'hBEEF, 0,0,0,0, 1,0,4'b1100,15'd4,32'hBEEF_BEEF, K_NONE,0);
    v[12] = mk(1,0,F3_H,32'h10,0, 0,0,0,0, 1,0,4'b0000,15'd4,0, K_CORE,32'h0000_5678);
    v[13] = mk(1,0,F3_B,32'h13,0, 0,0,0,0, 1,0,4'b0000,15'd4,0, K_CORE,32'hFFFF_FFBE);
    v[14] = mk(0,0,F3_B,0,0, 1,0,15'd2,0, 0,1,4'b0000,15'd2,0, K_LD,32'h8001_1234);
    v[15] = idle;
    for (int i = 0; i < 6; i++)
      v[16+i] = (i % 2 == 0) ?
        mk(1,0,F3_W,32'hC,0, 1,0,15'd4,0, 1,0,4'b0000,15'd3,0, K_CORE,32'hDEAD_BEEF) :
        mk(1,0,F3_W,32'hC,0, 1,0,15'd4,0, 0,1,4'b0000,15'd4,0, K_LD,32'hBEEF_5678);
    v[22] = idle;

    drive(idle);
    core_req = 1'b1; ld_req = 1'b1;
    repeat (2) @(negedge clk);
    check("rst core_gnt", core_gnt, 1'b0);
    check("rst ld_gnt", ld_gnt, 1'b0);
    check("rst mem_we", mem_we, 4'b0000);
    check("rst core_rvalid", core_rvalid, 1'b0);
    drive(idle);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) apply(v[i]);
    @(negedge clk);
    check_rsp();

    drive(mk(0,0,F3_B,0,0, 1,0,15'd3,0, 0,0,0,0,0,0,0));
    #1 check("mid ld_gnt", ld_gnt, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(idle);
    #1 check("mid ld_rvalid", ld_rvalid, 1'b0);
    check("mid ld_rdata", ld_rdata, 32'h0);
    @(negedge clk);
    check("mid ld_rvalid held", ld_rvalid, 1'b0);
    rst_n = 1'b1;
    core_req = 1'b1; ld_req = 1'b1; core_funct3 = F3_W; core_addr = 32'hC;
    #1 check("post-rst tie core_gnt", core_gnt, 1'b1);
    check("post-rst tie ld_gnt", ld_gnt, 1'b0);

    @(negedge clk);
    drive(mk(1,0,F3_W,32'hC,0, 0,0,0,0, 0,0,0,0,0,0,0));
    #1 check("core-only gnt", core_gnt, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(idle);
    #1 check("mid core_rvalid", core_rvalid, 1'b0);
    check("mid core_rdata", core_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    core_req = 1'b1; ld_req = 1'b1;
    #1 check("reset last_gnt tie core_gnt", core_gnt, 1'b1);
    check("reset last_gnt tie ld_gnt", ld_gnt, 1'b0);
    @(negedge clk);
    drive(idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
